pipe_latch_hs: RTL and testbench
================================

# pipe_latch_hs

Parametrised pipeline latch with valid/ready handshake, replacing the fixed per-stage latches between processor stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary-width packed stage payload, keeps the existing hazard-unit `enable` (stall) and `flush` controls, and adds an optional skid entry so that `in_ready` is registered and never combinationally depends on `out_ready`. One instance sits at each stage boundary.

## Interface
- `WIDTH`, 128, payload width in bits (packed stage struct, ≥1)
- `SKID`, 1, 1 = two-entry skid latch with registered `in_ready`; 0 = single register with combinational `in_ready`
- `FLUSH_VALUE`, '0, payload value loaded on reset and flush (NOP bubble)

- `CLK` in 1 — rising-edge clock
- `nRST` in 1 — asynchronous, active-low reset
- `enable` in 1 — 0 = stall: state frozen, both handshakes blocked
- `flush` in 1 — synchronous squash of all held entries
- `in_valid` in 1 — upstream payload valid
- `in_ready` out 1 — latch can accept this cycle
- `in_data` in WIDTH — upstream payload
- `out_valid` out 1 — `out_data` is valid
- `out_ready` in 1 — downstream accepts this cycle
- `out_data` out WIDTH — payload of the oldest held entry
- `occupancy` out 2 — entries held (0..2; ≤1 when SKID=0)

## Operation
- push = `in_valid && in_ready`; pop = `out_valid && out_ready`.
- `out_valid` = main_valid && `enable`; `out_data` = main register, always driven, even when not valid.
- SKID=1: `in_ready` = `enable` && !skid_valid (skid_valid is a flop, so no path from `out_ready`).
- SKID=0: `in_ready` = `enable` && (!main_valid || `out_ready`).
- States (SKID=1): EMPTY, FULL (main valid), SKID (main and skid valid). SKID=0 uses only EMPTY/FULL.
  - EMPTY: push → FULL, main ← in_data.
  - FULL: push&pop → FULL, main ← in_data. Push only → SKID, skid ← in_data. Pop only → EMPTY.
  - SKID: pop → FULL, main ← skid. Push cannot occur.
- Priority, highest first: `nRST`, `flush`, `enable`=0, handshakes.
- `flush`=1: next state EMPTY; main and skid ← FLUSH_VALUE. A push in the same cycle is discarded; a pop in the same cycle completes downstream and is not replayed.
- `enable`=0: no register changes. Handshakes are blocked by the masking of `in_ready`/`out_valid`.
- Order is strictly FIFO: the skid entry is always younger than main.
- `occupancy`: EMPTY=0, FULL=1, SKID=2.

## Timing
- Reset (async on `nRST` low): state EMPTY. `out_valid`=0, `occupancy`=0, `out_data`=FLUSH_VALUE, skid=FLUSH_VALUE. `in_ready`=1 only once `enable`=1.
- Latency: a payload pushed at edge N appears with `out_valid`=1 after edge N.
- Throughput: one transfer per cycle in steady state with `out_ready` held at 1, in both modes.
- SKID=1 absorbs exactly one beat after `out_ready` falls. `in_ready` drops the cycle after the skid fills and rises the cycle after the skid drains.
- Flush takes effect at the next edge: `out_valid`=0 in the following cycle, regardless of `enable`.
- `nRST` asserted mid-transfer: contents are lost immediately and outputs take reset values asynchronously. A pending handshake is not completed.

## Structure
- Package `pipe_pkg`: `typedef enum logic [1:0] {PIPE_EMPTY, PIPE_FULL, PIPE_SKID} pipe_state_t;`. Stage payload structs (e.g. `mem_wb_t`) also live there; `WIDTH` = `$bits(struct)`.
- Sub-module `pipe_slot`: WIDTH-bit register with `load`/`clear`, clear value FLUSH_VALUE, async `nRST`. Instantiate it twice for main and skid; generate the skid slot only when SKID=1.
- Top contains the state flop, next-state logic and handshake decode.

## Test plan
- Reset/idle: hold `nRST`=0, then release with `enable`=1 → `out_valid`=0, `out_data`=FLUSH_VALUE, `occupancy`=0, `in_ready`=1.
- Streaming: push 0x1, 0x2, 0x3 on consecutive cycles with `out_ready`=1 → same values appear one cycle later, back to back, `occupancy`=1 throughout.
- Backpressure (SKID=1): push 0xA, then 0xB while `out_ready`=0 → `occupancy`=2 and `in_ready`=0 next cycle. Raise `out_ready` → 0xA then 0xB pop in order, `in_ready` returns.
- Stall: `enable`=0 with `in_valid`=1 and 0xC held → `in_ready`=0, `out_valid`=0, contents unchanged. Restore `enable` → 0xC is delivered exactly once.
- Flush in SKID state with simultaneous push of 0xD → next cycle `occupancy`=0, `out_valid`=0, `out_data`=FLUSH_VALUE, and 0xD is never output.
- SKID=0 instance: `out_ready`=0 while FULL → `in_ready`=0 in the same cycle. `out_ready`=1 → push and pop occur in the same cycle, `occupancy` stays 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the stage-boundary pipeline latches: latch state encoding,
// an example stage payload, and a small occupancy helper.
package pipe_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY,
    PIPE_FULL,
    PIPE_SKID
  } pipe_state_t;

  // MEM/WB payload; instantiate the latch with WIDTH = $bits(mem_wb_t).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_to_reg;
    logic [24:0] rsvd;
  } mem_wb_t;

  localparam int MEM_WB_WIDTH = $bits(mem_wb_t);

  function automatic logic [1:0] occupancy_of(pipe_state_t s);
    case (s)
      PIPE_FULL: occupancy_of = 2'd1;
      PIPE_SKID: occupancy_of = 2'd2;
      default:   occupancy_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register of the pipeline latch: clear beats load, and both reset
// and clear restore the bubble value.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 128,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = '0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      q <= FLUSH_VALUE;
    end else if (clear) begin
      q <= FLUSH_VALUE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_latch_hs.sv
// Stage-boundary pipeline latch with valid/ready handshake, stall and flush.
// With SKID=1 a second entry absorbs one beat so in_ready comes from a flop.
module pipe_latch_hs
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 128,
  parameter int               SKID        = 1,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = '0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             enable,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  pipe_state_t      state_reg;
  logic             main_valid;
  logic             skid_valid;
  logic             push;
  logic             pop;
  logic             main_load;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_data;

  assign main_valid = (state_reg != PIPE_EMPTY);
  assign skid_valid = (state_reg == PIPE_SKID);
  assign out_valid  = main_valid && enable;
  assign occupancy  = occupancy_of(state_reg);

  // With a skid entry, in_ready depends only on the state flop, never on out_ready.
  generate
    if (SKID != 0) begin : g_rdy_skid
      assign in_ready = enable && !skid_valid;
    end else begin : g_rdy_direct
      assign in_ready = enable && (!main_valid || out_ready);
    end
  endgenerate

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Main refills from upstream on fill or pass-through, or from skid on drain.
  always_comb begin
    main_load = 1'b0;
    main_d    = in_data;
    if (!flush && enable) begin
      case (state_reg)
        PIPE_EMPTY: main_load = push;
        PIPE_FULL:  main_load = push && pop;
        PIPE_SKID: begin
          main_load = pop;
          main_d    = skid_data;
        end
        default:    main_load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= PIPE_EMPTY;
    end else if (flush) begin
      state_reg <= PIPE_EMPTY;
    end else if (enable) begin
      case (state_reg)
        PIPE_EMPTY: if (push) state_reg <= PIPE_FULL;
        PIPE_FULL: begin
          if (push && !pop && SKID != 0) state_reg <= PIPE_SKID;
          else if (pop && !push)         state_reg <= PIPE_EMPTY;
        end
        PIPE_SKID:  if (pop) state_reg <= PIPE_FULL;
        default:    state_reg <= PIPE_EMPTY;
      endcase
    end
  end

  pipe_slot #(
    .WIDTH       (WIDTH),
    .FLUSH_VALUE (FLUSH_VALUE)
  ) u_main (
    .CLK   (CLK),
    .nRST  (nRST),
    .load  (main_load),
    .clear (flush),
    .d     (main_d),
    .q     (out_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic skid_load;
      assign skid_load = enable && !flush && (state_reg == PIPE_FULL) && push && !pop;

      pipe_slot #(
        .WIDTH       (WIDTH),
        .FLUSH_VALUE (FLUSH_VALUE)
      ) u_skid (
        .CLK   (CLK),
        .nRST  (nRST),
        .load  (skid_load),
        .clear (flush),
        .d     (in_data),
        .q     (skid_data)
      );
    end else begin : g_no_skid
      assign skid_data = FLUSH_VALUE;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_latch_hs.sv
// Directed bench for pipe_latch_hs: one SKID=1 and one SKID=0 instance on a
// shared clock and reset, exercised one after the other.
module tb_pipe_latch_hs;

  localparam int         W  = 8;
  localparam logic [7:0] FV = 8'hEE;

  logic       clk;
  logic       rst_n;

  logic       en1, fl1, iv1, or1, ir1, ov1;
  logic [7:0] id1, od1;
  logic [1:0] occ1;

  logic       en0, fl0, iv0, or0, ir0, ov0;
  logic [7:0] id0, od0;
  logic [1:0] occ0;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_latch_hs #(.WIDTH(W), .SKID(1), .FLUSH_VALUE(FV)) u_dut_skid (
    .CLK(clk), .nRST(rst_n), .enable(en1), .flush(fl1),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(occ1)
  );

  pipe_latch_hs #(.WIDTH(W), .SKID(0), .FLUSH_VALUE(FV)) u_dut_direct (
    .CLK(clk), .nRST(rst_n), .enable(en0), .flush(fl0),
    .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .occupancy(occ0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    en1 = 1'b1; fl1 = 1'b0; iv1 = 1'b0; or1 = 1'b0; id1 = 8'h00;
    en0 = 1'b1; fl0 = 1'b0; iv0 = 1'b0; or0 = 1'b0; id0 = 8'h00;
    step(); step();
    chk("rst_ov1",   ov1,  1'b0);
    chk("rst_occ1",  occ1, 2'd0);
    chk("rst_od1",   od1,  FV);
    chk("rst_od0",   od0,  FV);
    rst_n = 1'b1;
    step();
    chk("idle_ir1",  ir1,  1'b1);
    chk("idle_ir0",  ir0,  1'b1);
    chk("idle_ov1",  ov1,  1'b0);

    // Streaming through the skid instance
    or1 = 1'b1; iv1 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      id1 = 8'(i);
      step();
      chk($sformatf("stream_od_%0d", i), od1, 8'(i));
      chk($sformatf("stream_ov_%0d", i), ov1, 1'b1);
      chk($sformatf("stream_occ_%0d", i), occ1, 2'd1);
    end
    iv1 = 1'b0;
    step();
    chk("stream_end_ov", ov1, 1'b0);
    chk("stream_end_occ", occ1, 2'd0);

    // Backpressure: skid absorbs one beat
    or1 = 1'b0; iv1 = 1'b1; id1 = 8'h0A;
    step();
    chk("bp_a_occ", occ1, 2'd1);
    chk("bp_a_ir",  ir1,  1'b1);
    id1 = 8'h0B;
    step();
    chk("bp_b_occ", occ1, 2'd2);
    chk("bp_b_ir",  ir1,  1'b0);
    chk("bp_b_od",  od1,  8'h0A);
    iv1 = 1'b0; or1 = 1'b1;
    step();
    chk("bp_pop_a_od",  od1,  8'h0B);
    chk("bp_pop_a_occ", occ1, 2'd1);
    chk("bp_pop_a_ir",  ir1,  1'b1);
    step();
    chk("bp_pop_b_occ", occ1, 2'd0);
    chk("bp_pop_b_ov",  ov1,  1'b0);

    // Stall with a held entry
    or1 = 1'b0; iv1 = 1'b1; id1 = 8'h0C;
    step();
    chk("stall_fill_od", od1, 8'h0C);
    en1 = 1'b0; id1 = 8'h55;
    #1;
    chk("stall_ir", ir1, 1'b0);
    chk("stall_ov", ov1, 1'b0);
    step(); step();
    chk("stall_od",  od1,  8'h0C);
    chk("stall_occ", occ1, 2'd1);
    en1 = 1'b1; iv1 = 1'b0; or1 = 1'b1;
    #1;
    chk("unstall_ov", ov1, 1'b1);
    chk("unstall_od", od1, 8'h0C);
    step();
    chk("unstall_once_ov",  ov1,  1'b0);
    chk("unstall_once_occ", occ1, 2'd0);

    // Flush from SKID state with a push of 0xD presented
    or1 = 1'b0; iv1 = 1'b1; id1 = 8'h11;
    step();
    id1 = 8'h12;
    step();
    chk("fl_pre_occ", occ1, 2'd2);
    fl1 = 1'b1; id1 = 8'h0D;
    step();
    fl1 = 1'b0; iv1 = 1'b0; or1 = 1'b1;
    chk("fl_occ", occ1, 2'd0);
    chk("fl_ov",  ov1,  1'b0);
    chk("fl_od",  od1,  FV);
    step();
    chk("fl_after_ov", ov1, 1'b0);

    // Flush from FULL: here the push is accepted by in_ready but discarded
    or1 = 1'b0; iv1 = 1'b1; id1 = 8'h22;
    step();
    fl1 = 1'b1; id1 = 8'h0D;
    step();
    fl1 = 1'b0; iv1 = 1'b0;
    chk("flf_occ", occ1, 2'd0);
    chk("flf_od",  od1,  FV);

    // Flush beats a stall
    iv1 = 1'b1; id1 = 8'h21;
    step();
    iv1 = 1'b0; en1 = 1'b0; fl1 = 1'b1;
    step();
    fl1 = 1'b0; en1 = 1'b1;
    chk("flst_occ", occ1, 2'd0);
    chk("flst_ov",  ov1,  1'b0);

    // SKID=0 instance
    or0 = 1'b1; iv0 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      id0 = 8'(i);
      step();
      chk($sformatf("d_stream_od_%0d", i), od0, 8'(i));
      chk($sformatf("d_stream_occ_%0d", i), occ0, 2'd1);
    end
    or0 = 1'b0; id0 = 8'h04;
    #1;
    chk("d_bp_ir", ir0, 1'b0);
    step();
    chk("d_bp_od",  od0,  8'h03);
    chk("d_bp_occ", occ0, 2'd1);
    or0 = 1'b1;
    #1;
    chk("d_rel_ir", ir0, 1'b1);
    step();
    chk("d_pp_od",  od0,  8'h04);
    chk("d_pp_occ", occ0, 2'd1);
    iv0 = 1'b0;
    step();
    chk("d_end_occ", occ0, 2'd0);
    chk("d_end_ov",  ov0,  1'b0);

    // Asynchronous reset mid-transfer
    iv1 = 1'b1; id1 = 8'h33; or1 = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_occ", occ1, 2'd0);
    chk("arst_od",  od1,  FV);
    chk("arst_ov",  ov1,  1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
